// File: rtl/aes_ctr_pkg.sv
// Shared types and constants for the AES-256 counter-mode engine.
// The byte-mask helper is used only when AES_CTR_BYTE_MASK_EN is defined.
package aes_ctr_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 256;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        WAIT_IN,
        OUT
    } ctr_state_e;

    // keep[i] guards bits [8*i+7:8*i], so keep[15] is the MSB byte
    function automatic logic [AES_BLOCK_W-1:0] byte_mask(input logic [AES_BLOCK_W-1:0] data,
                                                         input logic [15:0]            keep);
        logic [AES_BLOCK_W-1:0] m;
        m = data;
        for (int i = 0; i < 16; i++) begin
            if (!keep[i]) m[8*i +: 8] = 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/aes_ctr_engine_core.sv
// AESTop: iterative AES-256 block cipher, one round per clock, with the round
// keys expanded on the fly; en_i starts a block, done_o pulses when ciphertext_o is valid.
module AESTop
    import aes_ctr_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [AES_KEY_W-1:0]   key_i,
    input  logic [AES_BLOCK_W-1:0] plaintext_i,
    output logic [AES_BLOCK_W-1:0] ciphertext_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [3:0] LAST_ROUND = 4'd14;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            if (4'(i) < idx) r = xtime(r);
        end
        return r;
    endfunction

    // Next 128-bit round key from the two preceding ones (a older, b newer)
    function automatic logic [127:0] next_round_key(input logic [127:0] a, input logic [127:0] b,
                                                    input logic rot, input logic [7:0] rcon);
        logic [31:0] t, n0, n1, n2, n3;
        t  = rot ? (sub_word({b[23:0], b[31:24]}) ^ {rcon, 24'h0}) : sub_word(b[31:0]);
        n0 = a[127:96] ^ t;
        n1 = a[95:64]  ^ n0;
        n2 = a[63:32]  ^ n1;
        n3 = a[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [127:0] st_q, st_d;
    logic [127:0] ka_q, ka_d;
    logic [127:0] kb_q, kb_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [127:0] round_sub;

    always_comb begin
        st_d      = st_q;
        ka_d      = ka_q;
        kb_d      = kb_q;
        rnd_d     = rnd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        round_sub = sub_shift(st_q);
        if (!busy_q) begin
            if (en_i) begin
                st_d   = plaintext_i ^ key_i[255:128];
                ka_d   = key_i[127:0];
                kb_d   = next_round_key(key_i[255:128], key_i[127:0], 1'b1, 8'h01);
                rnd_d  = 4'd1;
                busy_d = 1'b1;
            end
        end else if (rnd_q == LAST_ROUND) begin
            st_d   = round_sub ^ ka_q;
            busy_d = 1'b0;
            done_d = 1'b1;
        end else begin
            // ka holds key for this round, kb the next; derive the one after
            st_d  = mix_columns(round_sub) ^ ka_q;
            ka_d  = kb_q;
            kb_d  = next_round_key(ka_q, kb_q, ~rnd_q[0], rcon_of({1'b0, rnd_q[3:1]} + 4'd1));
            rnd_d = rnd_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            st_q   <= '0;
            ka_q   <= '0;
            kb_q   <= '0;
            rnd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            ka_q   <= ka_d;
            kb_q   <= kb_d;
            rnd_q  <= rnd_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign ciphertext_o = st_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: rtl/aes_ctr_engine.sv
// AES-256 CTR streaming engine: sequences the AESTop core once per block and XORs the keystream
// into a valid/ready stream. Define AES_CTR_BYTE_MASK_EN to add in_keep_i for the last block.
module aes_ctr_engine
    import aes_ctr_pkg::*;
#(
    parameter int CTR_W = 32,
    parameter int LEN_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [AES_KEY_W-1:0]   key_i,
    input  logic [AES_BLOCK_W-1:0] iv_i,
    input  logic [LEN_W-1:0]       num_blocks_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [AES_BLOCK_W-1:0] in_data_i,
`ifdef AES_CTR_BYTE_MASK_EN
    input  logic [15:0]            in_keep_i,
`endif
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [AES_BLOCK_W-1:0] out_data_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   ctr_wrap_o
);

    ctr_state_e             state_q, state_d;
    logic [AES_KEY_W-1:0]   key_q, key_d;
    logic [AES_BLOCK_W-1:0] ctr_q, ctr_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic [AES_BLOCK_W-1:0] ks_q, ks_d;
    logic [AES_BLOCK_W-1:0] out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   wrap_q, wrap_d;
    logic                   done_q, done_d;

    logic                   core_en;
    logic [AES_BLOCK_W-1:0] core_ct;
    logic                   core_busy;
    logic                   core_done;
    logic [AES_BLOCK_W-1:0] in_blk;
    logic                   last_blk;

    assign last_blk = (rem_q == LEN_W'(1));

`ifdef AES_CTR_BYTE_MASK_EN
    assign in_blk = last_blk ? byte_mask(in_data_i ^ ks_q, in_keep_i) : (in_data_i ^ ks_q);
`else
    assign in_blk = in_data_i ^ ks_q;
`endif

    AESTop u_core (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .en_i        (core_en),
        .key_i       (key_q),
        .plaintext_i (ctr_q),
        .ciphertext_o(core_ct),
        .busy_o      (core_busy),
        .done_o      (core_done)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        ctr_d       = ctr_q;
        rem_d       = rem_q;
        ks_d        = ks_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        wrap_d      = wrap_q;
        done_d      = 1'b0;
        core_en     = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    key_d  = key_i;
                    ctr_d  = iv_i;
                    rem_d  = num_blocks_i;
                    wrap_d = 1'b0;
                    if (num_blocks_i != '0) state_d = GEN;
                    else                    done_d  = 1'b1;
                end
            end
            GEN: begin
                // Hold off en on the done cycle so the core is not relaunched
                core_en = !core_busy && !core_done;
                if (core_done) begin
                    ks_d    = core_ct;
                    state_d = WAIT_IN;
                end
            end
            WAIT_IN: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    out_data_d            = in_blk;
                    out_last_d            = last_blk;
                    ctr_d[CTR_W-1:0]      = ctr_q[CTR_W-1:0] + CTR_W'(1);
                    if (&ctr_q[CTR_W-1:0]) wrap_d = 1'b1;
                    rem_d                 = rem_q - LEN_W'(1);
                    state_d               = OUT;
                end
            end
            OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (rem_q != '0) begin
                        state_d = GEN;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            ctr_q      <= '0;
            rem_q      <= '0;
            ks_q       <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            ctr_q      <= ctr_d;
            rem_q      <= rem_d;
            ks_q       <= ks_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
        end
    end

    assign out_data_o = out_data_q;
    assign out_last_o = out_last_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign ctr_wrap_o = wrap_q;

endmodule

// File: tb/tb_aes_ctr_engine.sv
// Self-checking bench for aes_ctr_engine against a table-driven AES-256 reference model.
module tb_aes_ctr_engine;

    localparam int CTR_W = 32;
    localparam int LEN_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_i;
    logic [255:0]       key_i;
    logic [127:0]       iv_i;
    logic [LEN_W-1:0]   num_blocks_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [127:0]       in_data_i;
`ifdef AES_CTR_BYTE_MASK_EN
    logic [15:0]        in_keep_i;
`endif
    logic               out_valid_o;
    logic               out_ready_i;
    logic [127:0]       out_data_o;
    logic               out_last_o;
    logic               busy_o;
    logic               done_o;
    logic               ctr_wrap_o;

    always #5 clk = ~clk;

    aes_ctr_engine #(.CTR_W(CTR_W), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .key_i       (key_i),
        .iv_i        (iv_i),
        .num_blocks_i(num_blocks_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
`ifdef AES_CTR_BYTE_MASK_EN
        .in_keep_i   (in_keep_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ctr_wrap_o  (ctr_wrap_o)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]   sb [256];
    logic [127:0] msg_in  [16];
    logic [127:0] msg_out [16];
    logic [127:0] orig    [16];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $display("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 8'h00) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] aff_c = 8'h63;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff_c[i];
            end
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [127:0] aes256(input logic [255:0] key, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   rc = 8'h01;
        logic [31:0]  t;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[4*c+r] ^= w[c][31-8*r -: 8];
        for (int round = 1; round <= 14; round++) begin
            for (int k = 0; k < 16; k++) st[k] = sb[st[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) tmp[4*c+r] = st[4*((c+r)%4)+r];
            for (int k = 0; k < 16; k++) st[k] = tmp[k];
            if (round < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[4*c+r] ^= w[4*round+c][31-8*r -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
        return res;
    endfunction

    function automatic logic [127:0] ctr_blk(input logic [127:0] iv, input int k);
        logic [127:0] c = iv;
        c[CTR_W-1:0] = iv[CTR_W-1:0] + CTR_W'(k);
        return c;
    endfunction

    // ---------------- message driver ----------------
    task automatic run_msg(input logic [255:0] key, input logic [127:0] iv, input int n,
                           input int stall, input logic [15:0] keep, input bit poke);
        logic [127:0] exp;
        logic [63:0]  sum;
        int           cnt;
        int           s;
        @(negedge clk);
        start_i = 1'b1; key_i = key; iv_i = iv; num_blocks_i = LEN_W'(n);
        @(negedge clk);
        start_i = 1'b0; key_i = ~key; iv_i = ~iv; num_blocks_i = LEN_W'($urandom);
        chk("busy_after_start", busy_o, 1'b1);
        chk("wrap_cleared_on_start", ctr_wrap_o, 1'b0);
        for (int b = 0; b < n; b++) begin
            cnt = 0;
            while (!in_ready_o && cnt < 100) begin
                start_i = poke && (b == 0) && (cnt == 3);
                if (start_i) begin key_i = rand128(); num_blocks_i = '0; end
                @(negedge clk);
                cnt++;
            end
            start_i = 1'b0;
            if (cnt >= 100) begin timeout("in_ready_wait"); return; end
            in_valid_i = 1'b1;
            in_data_i  = msg_in[b];
`ifdef AES_CTR_BYTE_MASK_EN
            in_keep_i  = (b == n-1) ? keep : 16'($urandom);
`endif
            @(negedge clk);
            in_valid_i = 1'b0;
            in_data_i  = rand128();
            chk("in_ready_after_accept", in_ready_o, 1'b0);
            cnt = 0;
            while (!out_valid_o && cnt < 10) begin @(negedge clk); cnt++; end
            if (cnt >= 10) begin timeout("out_valid_wait"); return; end
            exp = msg_in[b] ^ aes256(key, ctr_blk(iv, b));
`ifdef AES_CTR_BYTE_MASK_EN
            if (b == n-1)
                for (int i = 0; i < 16; i++) if (!keep[i]) exp[8*i +: 8] = 8'h00;
`endif
            $display("msg n=%0d blk=%0d ctr=%h out=%h", n, b, ctr_blk(iv, b), out_data_o);
            chk("out_data", out_data_o, exp);
            chk("out_last", out_last_o, (b == n-1));
            msg_out[b] = out_data_o;
            s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int i = 0; i < s; i++) begin
                @(negedge clk);
                chk("stall_data_stable", out_data_o, exp);
                chk("stall_valid_held", out_valid_o, 1'b1);
                chk("stall_in_ready_low", in_ready_o, 1'b0);
                chk("stall_core_idle", dut.core_en, 1'b0);
            end
            out_ready_i = 1'b1;
            @(negedge clk);
            out_ready_i = 1'b0;
        end
        sum = 64'(iv[CTR_W-1:0]) + 64'(n);
        chk("done_pulse", done_o, 1'b1);
        chk("busy_falls_with_done", busy_o, 1'b0);
        chk("ctr_wrap", ctr_wrap_o, (sum >= (64'd1 << CTR_W)));
        @(negedge clk);
        chk("done_single_cycle", done_o, 1'b0);
    endtask

    logic [255:0] key0;
    logic [127:0] iv0;
    logic [255:0] k;
    logic [127:0] v;
    int           n;
    int           cnt;

    initial begin
        rst_n = 1'b0; start_i = 1'b0; key_i = '0; iv_i = '0; num_blocks_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
`ifdef AES_CTR_BYTE_MASK_EN
        in_keep_i = 16'hffff;
`endif
        build_sbox();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_in_ready", in_ready_o, 1'b0);
        chk("rst_out_data", out_data_o, '0);
        chk("rst_out_last", out_last_o, 1'b0);
        chk("rst_wrap", ctr_wrap_o, 1'b0);
        rst_n = 1'b1;

        // Known-answer single block
        key0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        iv0  = 128'h00112233445566778899aabbccddeeff;
        msg_in[0] = '0;
        run_msg(key0, iv0, 1, 0, 16'hffff, 1'b0);
        chk("known_answer", msg_out[0], 128'h8ea2b7ca516745bfeafc49904b496089);

        // Three blocks of zeros: raw keystream of iv, iv+1, iv+2
        for (int i = 0; i < 3; i++) msg_in[i] = '0;
        run_msg(key0, iv0, 3, -1, 16'hffff, 1'b0);

        // Round trip: second pass over the ciphertext recovers the plaintext
        k = {rand128(), rand128()}; v = rand128();
        for (int i = 0; i < 4; i++) begin msg_in[i] = rand128(); orig[i] = msg_in[i]; end
        run_msg(k, v, 4, -1, 16'hffff, 1'b0);
        for (int i = 0; i < 4; i++) msg_in[i] = msg_out[i];
        run_msg(k, v, 4, -1, 16'hffff, 1'b0);
        for (int i = 0; i < 4; i++) chk("round_trip", msg_out[i], orig[i]);

        // Counter wrap
        v = {rand128() >> 32, 32'hffffffff};
        for (int i = 0; i < 2; i++) msg_in[i] = '0;
        run_msg(key0, v, 2, 0, 16'hffff, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("wrap_sticky_idle", ctr_wrap_o, 1'b1);
        end

        // Long sink stall
        for (int i = 0; i < 2; i++) msg_in[i] = rand128();
        run_msg(key0, iv0, 2, 20, 16'hffff, 1'b0);

        // Zero-length message
        @(negedge clk);
        start_i = 1'b1; key_i = key0; iv_i = iv0; num_blocks_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        chk("zero_len_done", done_o, 1'b1);
        chk("zero_len_busy", busy_o, 1'b0);
        chk("zero_len_core_en", dut.core_en, 1'b0);
        @(negedge clk);
        chk("zero_len_done_clear", done_o, 1'b0);
        chk("zero_len_busy_low", busy_o, 1'b0);
        chk("zero_len_core_en2", dut.core_en, 1'b0);

        // start_i mid-message must be ignored
        for (int i = 0; i < 2; i++) msg_in[i] = rand128();
        run_msg({rand128(), rand128()}, rand128(), 2, -1, 16'hffff, 1'b1);

        // Random messages
        for (int m = 0; m < 4; m++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) msg_in[i] = rand128();
            run_msg({rand128(), rand128()}, rand128(), n, -1, 16'($urandom), 1'b0);
        end

`ifdef AES_CTR_BYTE_MASK_EN
        msg_in[0] = rand128();
        run_msg(key0, iv0, 1, 0, 16'hff00, 1'b0);
        chk("mask_low_bytes_zero", {64'h0, msg_out[0][63:0]}, '0);
`endif

        // Reset in the middle of a message, while a block is presented
        @(negedge clk);
        start_i = 1'b1; key_i = key0; iv_i = {96'h0, 32'hffffffff}; num_blocks_i = LEN_W'(3);
        @(negedge clk);
        start_i = 1'b0;
        cnt = 0;
        while (!in_ready_o && cnt < 100) begin @(negedge clk); cnt++; end
        if (cnt >= 100) timeout("rst_test_in_ready");
        in_valid_i = 1'b1; in_data_i = rand128();
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("pre_rst_valid", out_valid_o, 1'b1);
        chk("pre_rst_wrap", ctr_wrap_o, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        chk("midrst_out_valid", out_valid_o, 1'b0);
        chk("midrst_in_ready", in_ready_o, 1'b0);
        chk("midrst_out_data", out_data_o, '0);
        chk("midrst_out_last", out_last_o, 1'b0);
        chk("midrst_wrap", ctr_wrap_o, 1'b0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", done_o, 1'b0);
            chk("post_rst_idle", busy_o, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
